adder_arbiter: RTL and testbench

- Shares one 16-bit two's-complement adder (sum plus signed-overflow flag) among NUM_REQ requesters.
- Round-robin grant, one addition per accepted request, one-cycle latency.
- Single-entry registered result with valid/ready backpressure and a saturating overflow event counter.
- Sits between the lab datapath clients and the shared adder; the only path to the adder.

---
 rtl/adder_arbiter.sv | 125 ++++++++++++
 tb/tb_adder_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin access for NUM_REQ clients to one shared 16-bit adder.
// The result is registered and uses valid/ready. Define ADDER_ARB_SAT_EN to clamp overflowing sums.
module adder_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*16-1:0]   op_a,
  input  logic [NUM_REQ*16-1:0]   op_b,
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ID_W-1:0]         res_id,
  output logic [15:0]             res_sum,
  output logic                    res_ovf,
  output logic [7:0]              ovf_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] res_id_q, res_id_d;
  logic [15:0]     res_sum_q, res_sum_d;
  logic            res_ovf_q, res_ovf_d;
  logic [7:0]      ovf_count_q, ovf_count_d;

  logic [15:0]     a_arr [NUM_REQ];
  logic [15:0]     b_arr [NUM_REQ];
  logic [ID_W-1:0] win_idx, cand;
  logic            found, accept, grant_en, sum_ovf;
  logic [15:0]     a_sel, b_sel, raw_sum, final_sum;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = op_a[16*i +: 16];
      b_arr[i] = op_b[16*i +: 16];
    end
  end

  // Search upward from the last winner, wrapping; the first requester found wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = ID_W'((int'(rr_ptr_q) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign res_valid = (state_q == FULL);
  assign accept    = ~res_valid | res_ready;
  assign grant_en  = accept & found & ~rst;

  always_comb begin
    gnt = '0;
    if (grant_en) gnt[win_idx] = 1'b1;
  end

  assign a_sel   = a_arr[win_idx];
  assign b_sel   = b_arr[win_idx];
  assign raw_sum = a_sel + b_sel;
  assign sum_ovf = (a_sel[15] & b_sel[15] & ~raw_sum[15]) |
                   (~a_sel[15] & ~b_sel[15] & raw_sum[15]);

  always_comb begin
    final_sum = raw_sum;
`ifdef ADDER_ARB_SAT_EN
    if (sum_ovf) final_sum = a_sel[15] ? 16'h8000 : 16'h7FFF;
`endif
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    res_id_d    = res_id_q;
    res_sum_d   = res_sum_q;
    res_ovf_d   = res_ovf_q;
    ovf_count_d = ovf_count_q;

    // Count overflowing results only when the consumer takes them.
    if (res_valid && res_ready && res_ovf_q && ovf_count_q != 8'hFF)
      ovf_count_d = ovf_count_q + 8'd1;

    if (grant_en) begin
      state_d   = FULL;
      rr_ptr_d  = win_idx;
      res_id_d  = win_idx;
      res_sum_d = final_sum;
      res_ovf_d = sum_ovf;
    end else if (state_q == FULL && res_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      res_id_q    <= '0;
      res_sum_q   <= '0;
      res_ovf_q   <= 1'b0;
      ovf_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      res_id_q    <= res_id_d;
      res_sum_q   <= res_sum_d;
      res_ovf_q   <= res_ovf_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  assign res_id    = res_id_q;
  assign res_sum   = res_sum_q;
  assign res_ovf   = res_ovf_q;
  assign ovf_count = ovf_count_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios then randomized traffic, checked against
// a signed-arithmetic round-robin reference model.
module tb_adder_arbiter;

  localparam int NUM_REQ = 4;

`ifdef ADDER_ARB_SAT_EN
  localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] EXP_POS_OVF = 16'h8000;
  localparam logic [15:0] EXP_NEG_OVF = 16'h7FFF;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] op_a, op_b;
  logic [3:0]  gnt;
  logic        res_valid, res_ready;
  logic [1:0]  res_id;
  logic [15:0] res_sum;
  logic        res_ovf;
  logic [7:0]  ovf_count;

  logic [15:0] a_arr [4];
  logic [15:0] b_arr [4];
  logic [15:0] nxt_a [4];
  logic [15:0] nxt_b [4];

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          m_valid;
  int          m_id;
  logic [15:0] m_sum;
  bit          m_ovf;
  int          m_cnt;
  int          m_ptr;
  int          last_win;

  always #5 clk = ~clk;

  assign op_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign op_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

  adder_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_ovf   (res_ovf),
    .ovf_count (ovf_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void modelAdd(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] s, output bit o);
    int sa;
    int sb;
    int t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    t  = sa + sb;
    o  = (t > 32767) || (t < -32768);
    s  = t[15:0];
`ifdef ADDER_ARB_SAT_EN
    if (o) s = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
  endfunction

  task automatic modelReset();
    m_valid = 0;
    m_id    = 0;
    m_sum   = 16'h0;
    m_ovf   = 0;
    m_cnt   = 0;
    m_ptr   = NUM_REQ - 1;
  endtask

  // One clock: drive inputs at negedge, check against the model, then advance the model.
  task automatic applyStimulus(input logic [3:0] r, input logic rdy, input logic rs);
    int          win;
    logic [3:0]  exp_gnt;
    logic [15:0] s;
    bit          o;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = nxt_a[i];
      b_arr[i] = nxt_b[i];
    end
    req       = r;
    res_ready = rdy;
    rst       = rs;
    #1;
    win     = -1;
    exp_gnt = 4'b0000;
    if (!rs && (!m_valid || rdy)) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (win < 0 && r[2'(idx)]) win = idx;
      end
    end
    if (win >= 0) exp_gnt[2'(win)] = 1'b1;
    last_win = win;

    checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
    checkOutput("res_valid", 32'(res_valid), 32'(m_valid));
    if (m_valid) begin
      checkOutput("res_id", 32'(res_id), 32'(m_id));
      checkOutput("res_sum", 32'(res_sum), 32'(m_sum));
      checkOutput("res_ovf", 32'(res_ovf), 32'(m_ovf));
    end
    checkOutput("ovf_count", 32'(ovf_count), 32'(m_cnt));

    @(posedge clk);
    if (rs) begin
      modelReset();
    end else begin
      if (m_valid && rdy && m_ovf && m_cnt < 255) m_cnt++;
      if (win >= 0) begin
        modelAdd(a_arr[win], b_arr[win], s, o);
        m_valid = 1;
        m_id    = win;
        m_sum   = s;
        m_ovf   = o;
        m_ptr   = win;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic checkReset(input string tag);
    #2;
    checkOutput({tag, "_valid"}, 32'(res_valid), 32'h0);
    checkOutput({tag, "_id"},    32'(res_id),    32'h0);
    checkOutput({tag, "_sum"},   32'(res_sum),   32'h0);
    checkOutput({tag, "_ovf"},   32'(res_ovf),   32'h0);
    checkOutput({tag, "_cnt"},   32'(ovf_count), 32'h0);
  endtask

  initial begin
    logic [3:0] pend;
    logic       rdy;

    rst       = 1'b1;
    req       = 4'b0000;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = 16'h0;
      b_arr[i] = 16'h0;
      nxt_a[i] = 16'h0;
      nxt_b[i] = 16'h0;
    end
    repeat (2) @(posedge clk);
    modelReset();
    checkReset("reset");

    // Single requester, simple add
    nxt_a[0] = 16'h0003;
    nxt_b[0] = 16'h0004;
    applyStimulus(4'b0001, 1'b1, 1'b0);
    #2;
    checkOutput("t1_sum", 32'(res_sum), 32'h7);
    checkOutput("t1_id", 32'(res_id), 32'h0);
    applyStimulus(4'b0000, 1'b1, 1'b0);

    // All requesting: order 0,1,2,3,0 after reset
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkReset("rr_reset");
    for (int i = 0; i < 4; i++) begin
      nxt_a[i] = 16'(16'h0100 * (i + 1));
      nxt_b[i] = 16'(i);
    end
    for (int c = 0; c < 5; c++) applyStimulus(4'b1111, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);

    // Signed overflow in both directions
    applyStimulus(4'b0000, 1'b0, 1'b1);
    nxt_a[1] = 16'h7FFF;
    nxt_b[1] = 16'h0001;
    applyStimulus(4'b0010, 1'b1, 1'b0);
    #2;
    checkOutput("pos_ovf_sum", 32'(res_sum), 32'(EXP_POS_OVF));
    checkOutput("pos_ovf_flag", 32'(res_ovf), 32'h1);
    nxt_a[2] = 16'h8000;
    nxt_b[2] = 16'hFFFF;
    applyStimulus(4'b0100, 1'b1, 1'b0);
    #2;
    checkOutput("neg_ovf_sum", 32'(res_sum), 32'(EXP_NEG_OVF));
    checkOutput("neg_ovf_flag", 32'(res_ovf), 32'h1);
    applyStimulus(4'b0000, 1'b1, 1'b0);

    // Backpressure: hold result while requesters 1 and 2 wait
    applyStimulus(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      nxt_a[i] = 16'(16'h1111 * (i + 1));
      nxt_b[i] = 16'h0022;
    end
    applyStimulus(4'b0001, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) applyStimulus(4'b0110, 1'b0, 1'b0);
    applyStimulus(4'b0110, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);

    // Overflow counter: a held overflow is not counted, then saturation
    applyStimulus(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      nxt_a[i] = 16'h8000;
      nxt_b[i] = 16'h8000;
    end
    applyStimulus(4'b0001, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 1'b0, 1'b0);
    #2;
    checkOutput("held_ovf_cnt", 32'(ovf_count), 32'h0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    #2;
    checkOutput("first_ovf_cnt", 32'(ovf_count), 32'h1);
    for (int c = 0; c < 300; c++) applyStimulus(4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    #2;
    checkOutput("sat_ovf_cnt", 32'(ovf_count), 32'd255);

    // Reset while a result is held and requester 3 waits
    applyStimulus(4'b0000, 1'b0, 1'b1);
    nxt_a[3] = 16'h0010;
    nxt_b[3] = 16'h0020;
    applyStimulus(4'b1000, 1'b1, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b1);
    checkReset("mid_reset");
    applyStimulus(4'b1000, 1'b1, 1'b0);
    #2;
    checkOutput("post_reset_id", 32'(res_id), 32'h3);
    applyStimulus(4'b0000, 1'b1, 1'b0);

    // Randomized traffic: requests stay up with stable operands until granted
    pend = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          nxt_a[i] = 16'($urandom);
          nxt_b[i] = 16'($urandom);
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(pend, rdy, 1'b0);
      if (last_win >= 0) pend[2'(last_win)] = 1'b0;
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
